// File: rtl/lift_pkg.sv
// Shared definitions for the lift car controller: state encoding, direction
// constants and the timer width helper.
package lift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_DOOR
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Bits needed to hold (max(a,b) - 1), never less than one.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/lift_tick_timer.sv
// Loadable down-counter advanced only on slowref ticks; saturates at zero
// and flags it. Used for both travel and door dwell timing.
module lift_tick_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      if (load)
        count <= load_val;
      else if (count != '0)
        count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lift_car_ctrl.sv
// Single-car collective-scheduling lift controller. Optional macro
// LIFT_DOOR_HOLD_EN lets a same-direction hall call at the open floor hold the door.
module lift_car_ctrl
  import lift_pkg::*;
#(
  parameter int unsigned NFLOOR = 4,
  parameter int unsigned TRAVEL = 4,
  parameter int unsigned DOOR   = 6
) (
  input  logic                      clk,
  input  logic                      resetb,
  input  logic                      slowref,
  input  logic [NFLOOR-1:0]         req_up,
  input  logic [NFLOOR-1:0]         req_dn,
  output logic [NFLOOR-1:0]         clrup,
  output logic [NFLOOR-1:0]         clrdn,
  output logic [$clog2(NFLOOR)-1:0] floor,
  output logic                      dir,
  output logic                      moving,
  output logic                      door_open
);

  localparam int unsigned FW = $clog2(NFLOOR);
  localparam int unsigned TW = timer_width(TRAVEL, DOOR);
  localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL - 1);
  localparam logic [TW-1:0] DOOR_LD   = TW'(DOOR - 1);
  localparam logic [FW-1:0] TOP       = FW'(NFLOOR - 1);

  state_t            state, state_nxt;
  logic [FW-1:0]     floor_nxt, g;
  logic              dir_nxt;
  logic [NFLOOR-1:0] clrup_nxt, clrdn_nxt, any;
  logic              t_load, t_zero;
  logic [TW-1:0]     t_val;

  function automatic logic above(input logic [NFLOOR-1:0] r, input logic [FW-1:0] f);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NFLOOR; i++)
      if (i > 32'(f) && r[i]) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic below(input logic [NFLOOR-1:0] r, input logic [FW-1:0] f);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NFLOOR; i++)
      if (i < 32'(f) && r[i]) hit = 1'b1;
    return hit;
  endfunction

  lift_tick_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (resetb),
    .tick     (slowref),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= ST_IDLE;
      floor <= '0;
      dir   <= DIR_UP;
      clrup <= '0;
      clrdn <= '0;
    end else begin
      state <= state_nxt;
      floor <= floor_nxt;
      dir   <= dir_nxt;
      clrup <= clrup_nxt;
      clrdn <= clrdn_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    floor_nxt = floor;
    dir_nxt   = dir;
    clrup_nxt = '0;
    clrdn_nxt = '0;
    t_load    = 1'b0;
    t_val     = TRAVEL_LD;
    g         = floor;
    any       = req_up | req_dn;
    if (slowref) begin
      unique case (state)
        ST_IDLE: begin
          if (req_up[floor]) begin
            state_nxt = ST_DOOR; clrup_nxt[floor] = 1'b1; dir_nxt = DIR_UP;
            t_load = 1'b1; t_val = DOOR_LD;
          end else if (req_dn[floor]) begin
            state_nxt = ST_DOOR; clrdn_nxt[floor] = 1'b1; dir_nxt = DIR_DN;
            t_load = 1'b1; t_val = DOOR_LD;
          end else if (above(any, floor)) begin
            state_nxt = ST_MOVE; dir_nxt = DIR_UP; t_load = 1'b1;
          end else if (below(any, floor)) begin
            state_nxt = ST_MOVE; dir_nxt = DIR_DN; t_load = 1'b1;
          end
        end
        ST_MOVE: begin
          // The stop decision is taken on the floor being arrived at, in the same tick.
          if (t_zero) begin
            if (dir == DIR_UP) begin
              if (floor == TOP) begin
                state_nxt = ST_IDLE;
              end else begin
                g = floor + 1'b1;
                floor_nxt = g;
                if (req_up[g]) begin
                  state_nxt = ST_DOOR; clrup_nxt[g] = 1'b1;
                  t_load = 1'b1; t_val = DOOR_LD;
                end else if (!above(any, g) && req_dn[g]) begin
                  state_nxt = ST_DOOR; clrdn_nxt[g] = 1'b1; dir_nxt = DIR_DN;
                  t_load = 1'b1; t_val = DOOR_LD;
                end else if (!above(any, g)) begin
                  state_nxt = ST_IDLE;
                end else begin
                  t_load = 1'b1;
                end
              end
            end else begin
              if (floor == '0) begin
                state_nxt = ST_IDLE;
              end else begin
                g = floor - 1'b1;
                floor_nxt = g;
                if (req_dn[g]) begin
                  state_nxt = ST_DOOR; clrdn_nxt[g] = 1'b1;
                  t_load = 1'b1; t_val = DOOR_LD;
                end else if (!below(any, g) && req_up[g]) begin
                  state_nxt = ST_DOOR; clrup_nxt[g] = 1'b1; dir_nxt = DIR_UP;
                  t_load = 1'b1; t_val = DOOR_LD;
                end else if (!below(any, g)) begin
                  state_nxt = ST_IDLE;
                end else begin
                  t_load = 1'b1;
                end
              end
            end
          end
        end
        ST_DOOR: begin
`ifdef LIFT_DOOR_HOLD_EN
          if (dir == DIR_UP && req_up[floor]) begin
            clrup_nxt[floor] = 1'b1; t_load = 1'b1; t_val = DOOR_LD;
          end else if (dir == DIR_DN && req_dn[floor]) begin
            clrdn_nxt[floor] = 1'b1; t_load = 1'b1; t_val = DOOR_LD;
          end else if (t_zero) begin
            state_nxt = ST_IDLE;
          end
`else
          if (t_zero) state_nxt = ST_IDLE;
`endif
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    moving    = (state == ST_MOVE);
    door_open = (state == ST_DOOR);
  end

endmodule

// File: tb/tb_lift_car_ctrl.sv
// Scoreboard bench for lift_car_ctrl: stimulus queues expected output changes,
// a monitor pops one entry per observed output change and checks value and tick.
module tb_lift_car_ctrl;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       slowref;
  logic [3:0] req_up = '0, req_dn = '0, set_up = '0, set_dn = '0;
  logic [3:0] clrup, clrdn;
  logic [1:0] floor;
  logic       dir, moving, door_open;

  int unsigned ph = 0;
  int tcount = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [1:0] fl;
    logic       dr, mv, dp;
    logic [3:0] cu, cd;
  } obs_t;

  typedef struct {
    obs_t v;
    int   t;
  } exp_t;

  exp_t q[$];
  exp_t e;
  obs_t prev, cur;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  assign slowref = (ph == 3);

  always @(posedge clk) begin
    ph <= (ph + 1) % 4;
    if (slowref) tcount <= tcount + 1;
  end

  // Floor LED stages: latch set requests, drop them when the car clears them.
  always @(posedge clk) begin
    req_up <= (req_up | set_up) & ~clrup;
    req_dn <= (req_dn | set_dn) & ~clrdn;
  end

  lift_car_ctrl #(.NFLOOR(4), .TRAVEL(2), .DOOR(3)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .slowref   (slowref),
    .req_up    (req_up),
    .req_dn    (req_dn),
    .clrup     (clrup),
    .clrdn     (clrdn),
    .floor     (floor),
    .dir       (dir),
    .moving    (moving),
    .door_open (door_open)
  );

  function automatic string fmt(input obs_t o);
    return $sformatf("floor=%0d dir=%0b moving=%0b door=%0b clrup=%b clrdn=%b",
                     o.fl, o.dr, o.mv, o.dp, o.cu, o.cd);
  endfunction

  always @(negedge clk) begin
    cur = {floor, dir, moving, door_open, clrup, clrdn};
    if (mon_en && cur !== prev) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_change: got %s at tick %0d, expected no change", fmt(cur), tcount);
      end else begin
        e = q.pop_front();
        if (cur !== e.v || tcount != e.t) begin
          miscompares++;
          $display("FAIL output_change: got %s at tick %0d, expected %s at tick %0d",
                   fmt(cur), tcount, fmt(e.v), e.t);
        end
      end
    end
    prev = cur;
  end

  task automatic push(input int t, input logic [1:0] f, input logic d, input logic m,
                      input logic o, input logic [3:0] cu, input logic [3:0] cd);
    exp_t x;
    x.v = {f, d, m, o, cu, cd};
    x.t = t;
    q.push_back(x);
  endtask

  task automatic push_reset(input int t);
    push(t, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
  endtask

  // Leaves time #1 after the posedge that followed a tick.
  task automatic align();
    forever begin
      @(posedge clk);
      #1;
      if (ph == 0) break;
    end
  endtask

  task automatic set_req(input logic [3:0] up, input logic [3:0] dn);
    set_up = up;
    set_dn = dn;
    @(posedge clk);
    #1;
    set_up = '0;
    set_dn = '0;
  endtask

  task automatic reset_dut();
    align();
    push_reset(tcount);
    resetb = 1'b0;
    @(posedge clk);
    #1;
    resetb = 1'b1;
  endtask

  task automatic wait_tick(input int t);
    while (tcount < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: %0d expected changes still pending, required 0", name, q.size());
      q.delete();
    end
    repeat (12) @(posedge clk);
  endtask

  initial begin
    int b;
    repeat (3) @(posedge clk);
    #1;
    resetb = 1'b1;
    @(negedge clk);
    vectors++;
    if ({floor, dir, moving, door_open, clrup, clrdn} !== 13'b00_1_0_0_0000_0000) begin
      miscompares++;
      $display("FAIL reset_state: got floor=%0d dir=%0b moving=%0b door=%0b clrup=%b clrdn=%b, required 0 1 0 0 0000 0000",
               floor, dir, moving, door_open, clrup, clrdn);
    end
    mon_en = 1'b1;

    // Call at the current floor: door at tick 1, open for 3 ticks.
    align(); b = tcount;
    push(b+1, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000);
    push(b+1, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    push(b+4, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    set_req(4'b0001, 4'b0000);
    wait_done("local_call");

    // Down call three floors up.
    align(); b = tcount;
    push(b+1,  2'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    push(b+3,  2'd1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    push(b+5,  2'd2, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    push(b+7,  2'd3, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1000);
    push(b+7,  2'd3, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    push(b+10, 2'd3, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    set_req(4'b0000, 4'b1000);
    wait_done("far_call");

    // Down call at 1 while going up to 3 is served on the way back.
    reset_dut();
    align(); b = tcount;
    push(b+1,  2'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    push(b+3,  2'd1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    push(b+5,  2'd2, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    push(b+7,  2'd3, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1000);
    push(b+7,  2'd3, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    push(b+10, 2'd3, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    push(b+11, 2'd3, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    push(b+13, 2'd2, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    push(b+15, 2'd1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0010);
    push(b+15, 2'd1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    push(b+18, 2'd1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    set_req(4'b0000, 4'b1000);
    wait_tick(b+1);
    set_req(4'b0000, 4'b0010);
    wait_done("collective");

    // Move to floor 2, then both calls there: up first, down one tick after close.
    align(); b = tcount;
    push(b+1, 2'd1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    push(b+3, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000);
    push(b+3, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    push(b+6, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    set_req(4'b0100, 4'b0000);
    wait_done("to_floor2");

    align(); b = tcount;
    push(b+1, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000);
    push(b+1, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    push(b+4, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    push(b+5, 2'd2, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0100);
    push(b+5, 2'd2, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    push(b+8, 2'd2, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
    set_req(4'b0100, 4'b0100);
    wait_done("both_at_floor");

    // Reset mid-move between 1 and 2; the latched call to 3 is served afterwards.
    reset_dut();
    align(); b = tcount;
    push(b+1, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    push(b+3, 2'd1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    set_req(4'b1000, 4'b0000);
    wait_tick(b+4);
    push_reset(b+4);
    resetb = 1'b0;
    #1;
    vectors++;
    if (floor !== 2'd0 || moving !== 1'b0 || dir !== 1'b1 || door_open !== 1'b0 ||
        clrup !== 4'b0000 || clrdn !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_reset: got floor=%0d dir=%0b moving=%0b door=%0b clrup=%b clrdn=%b, required 0 1 0 0 0000 0000",
               floor, dir, moving, door_open, clrup, clrdn);
    end
    push(b+5,  2'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    push(b+7,  2'd1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    push(b+9,  2'd2, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
    push(b+11, 2'd3, 1'b1, 1'b0, 1'b1, 4'b1000, 4'b0000);
    push(b+11, 2'd3, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    push(b+14, 2'd3, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    resetb = 1'b1;
    wait_done("reset_resume");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
